// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Single-port memory arbiter for IF / DM / LD with starvation promotion and a loader burst lock.
// Optional grant statistics outputs are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter #(
   parameter int AW         = 10,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          halted,
   input  logic          if_req,
   input  logic          dm_req,
   input  logic          ld_req,
   input  logic          dm_we,
   input  logic          ld_we,
   input  logic [AW-1:0] if_addr,
   input  logic [AW-1:0] dm_addr,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] dm_wdata,
   input  logic [DW-1:0] ld_wdata,
   input  logic          ld_lock,
   output logic          if_gnt,
   output logic          dm_gnt,
   output logic          ld_gnt,
   output logic          if_rvalid,
   output logic          dm_rvalid,
   output logic          ld_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]   stat_if_cnt,
   output logic [31:0]   stat_dm_cnt,
   output logic [31:0]   stat_ld_cnt
`endif
);

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_IF   = 2'd1;
   localparam logic [1:0] TAG_DM   = 2'd2;
   localparam logic [1:0] TAG_LD   = 2'd3;

   logic          if_eff;
   logic [3:0]    if_cnt_q, if_cnt_d;
   logic [3:0]    dm_cnt_q, dm_cnt_d;
   logic [3:0]    ld_cnt_q, ld_cnt_d;
   logic          lock_q, lock_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]    tag_q, tag_d;
   logic [2:0]    rvalid_q, rvalid_d;

   function automatic logic [3:0] next_cnt(input logic req, input logic gnt, input logic [3:0] cnt);
      if (!req || gnt)
         return '0;
      else if (cnt == SMAX)
         return cnt;
      else
         return cnt + 4'd1;
   endfunction

   assign if_eff = if_req & ~halted;

   // Grants are forced low while reset is asserted since they are combinational.
   always_comb begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
      ld_gnt = 1'b0;
      if (!rst_n) begin
         if_gnt = 1'b0;
      end else if (lock_q) begin
         ld_gnt = ld_req;
      end else if (dm_req && dm_cnt_q == SMAX) begin
         dm_gnt = 1'b1;
      end else if (if_eff && if_cnt_q == SMAX) begin
         if_gnt = 1'b1;
      end else if (ld_req && ld_cnt_q == SMAX) begin
         ld_gnt = 1'b1;
      end else if (dm_req) begin
         dm_gnt = 1'b1;
      end else if (if_eff) begin
         if_gnt = 1'b1;
      end else if (ld_req) begin
         ld_gnt = 1'b1;
      end
   end

   always_comb begin
      if_cnt_d = next_cnt(if_eff, if_gnt, if_cnt_q);
      dm_cnt_d = next_cnt(dm_req, dm_gnt, dm_cnt_q);
      ld_cnt_d = next_cnt(ld_req, ld_gnt, ld_cnt_q);
      if (!ld_lock)
         lock_d = 1'b0;
      else if (ld_gnt)
         lock_d = 1'b1;
      else
         lock_d = lock_q;
   end

   always_comb begin
      mem_en_d    = if_gnt | dm_gnt | ld_gnt;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      tag_d       = TAG_NONE;
      if (if_gnt) begin
         mem_addr_d = if_addr;
         tag_d      = TAG_IF;
      end else if (dm_gnt) begin
         mem_we_d    = dm_we;
         mem_addr_d  = dm_addr;
         mem_wdata_d = dm_wdata;
         tag_d       = TAG_DM;
      end else if (ld_gnt) begin
         mem_we_d    = ld_we;
         mem_addr_d  = ld_addr;
         mem_wdata_d = ld_wdata;
         tag_d       = TAG_LD;
      end
   end

   // Read data arrives from the memory one cycle after the strobe; steer the valid to the tagged owner.
   always_comb begin
      rvalid_d = '0;
      if (mem_en_q && !mem_we_q) begin
         case (tag_q)
            TAG_IF:  rvalid_d = 3'b100;
            TAG_DM:  rvalid_d = 3'b010;
            TAG_LD:  rvalid_d = 3'b001;
            default: rvalid_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         if_cnt_q    <= '0;
         dm_cnt_q    <= '0;
         ld_cnt_q    <= '0;
         lock_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         tag_q       <= TAG_NONE;
         rvalid_q    <= '0;
      end else begin
         if_cnt_q    <= if_cnt_d;
         dm_cnt_q    <= dm_cnt_d;
         ld_cnt_q    <= ld_cnt_d;
         lock_q      <= lock_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         tag_q       <= tag_d;
         rvalid_q    <= rvalid_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rvalid = rvalid_q[2];
   assign dm_rvalid = rvalid_q[1];
   assign ld_rvalid = rvalid_q[0];
   assign rdata     = (|rvalid_q) ? mem_rdata : '0;

`ifdef MEM_ARB_STATS_EN
   logic [31:0] st_if_q, st_dm_q, st_ld_q;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         st_if_q <= '0;
         st_dm_q <= '0;
         st_ld_q <= '0;
      end else begin
         if (if_gnt && st_if_q != '1) st_if_q <= st_if_q + 32'd1;
         if (dm_gnt && st_dm_q != '1) st_dm_q <= st_dm_q + 32'd1;
         if (ld_gnt && st_ld_q != '1) st_ld_q <= st_ld_q + 32'd1;
      end
   end

   assign stat_if_cnt = st_if_q;
   assign stat_dm_cnt = st_dm_q;
   assign stat_ld_cnt = st_ld_q;
`endif

endmodule
